// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl_pkg
// Brief    : Default limits and FSM state encodings for the clock divider.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_ctrl_pkg;

    localparam int c_LIM_W_DEF   = 8;
    localparam int c_LIM_MIN_DEF = 1;
    localparam int c_LIM_MAX_DEF = 200;
    localparam int c_LIM_RST_DEF = 1;

    localparam logic [1:0] c_ST_STOP = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_STEP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_core
// Brief    : Half-period counter with active limit, divided clock and tick.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_core #(
    parameter int LIM_W   = 8,
    parameter int LIM_RST = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [LIM_W-1:0] i_limit,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_wrap,
    output logic [LIM_W-1:0] o_active
);

    logic [LIM_W-1:0] r_cnt;
    logic [LIM_W-1:0] r_active;
    logic             r_clk;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = i_enable && (r_cnt == r_active);

    // The new limit is adopted only at a wrap (or while stopped), so a
    // half-period is never cut short.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt    <= '0;
            r_active <= LIM_W'(LIM_RST);
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (w_wrap) begin
                r_cnt    <= '0;
                r_clk    <= ~r_clk;
                r_active <= i_limit;
            end else if (i_enable) begin
                r_cnt <= r_cnt + LIM_W'(1);
            end else if (i_load) begin
                r_cnt    <= '0;
                r_active <= i_limit;
            end
        end
    end

    assign o_clk    = r_clk;
    assign o_tick   = r_tick;
    assign o_wrap   = w_wrap;
    assign o_active = r_active;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Command decode and RUN/STOP/STEP control for a programmable divider.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int LIM_W   = c_LIM_W_DEF,
    parameter int LIM_MIN = c_LIM_MIN_DEF,
    parameter int LIM_MAX = c_LIM_MAX_DEF,
    parameter int LIM_RST = c_LIM_RST_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_run_tgl,
    input  logic             i_step,
    input  logic             i_show_tgl,
    output logic             o_clk_div,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic [LIM_W-1:0] o_limit,
    output logic             o_running,
    output logic             o_show,
    output logic             o_pend
);

    localparam logic [LIM_W-1:0] c_MIN = LIM_W'(LIM_MIN);
    localparam logic [LIM_W-1:0] c_MAX = LIM_W'(LIM_MAX);
    localparam logic [LIM_W-1:0] c_RST = LIM_W'(LIM_RST);

    logic [1:0]       r_state,  w_state_nxt;
    logic [LIM_W-1:0] r_shadow, w_shadow_nxt;
    logic             r_show,   w_show_nxt;
    logic             r_step_half, w_step_half_nxt;
    logic             r_pend;
    logic             r_running;
    logic [LIM_W-1:0] w_active, w_active_nxt;
    logic             w_enable, w_load, w_wrap, w_clk_div, w_tick;

    assign w_enable     = (r_state != c_ST_STOP);
    assign w_load       = (r_state == c_ST_STOP) && (r_shadow != w_active);
    assign w_active_nxt = (w_wrap || w_load) ? r_shadow : w_active;

    clk_div_core #(
        .LIM_W   (LIM_W),
        .LIM_RST (LIM_RST)
    ) u_core (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (w_enable),
        .i_load    (w_load),
        .i_limit   (r_shadow),
        .o_clk     (w_clk_div),
        .o_tick    (w_tick),
        .o_wrap    (w_wrap),
        .o_active  (w_active)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_show_nxt      = r_show;
        w_step_half_nxt = r_step_half;

        // A step covers a full period: stop again on the second toggle.
        if ((r_state == c_ST_STEP) && w_wrap) begin
            if (r_step_half) w_state_nxt     = c_ST_STOP;
            else             w_step_half_nxt = 1'b1;
        end

        if (i_inc) begin
            if (r_shadow < c_MAX) w_shadow_nxt = r_shadow + LIM_W'(1);
        end else if (i_dec) begin
            if (r_shadow > c_MIN) w_shadow_nxt = r_shadow - LIM_W'(1);
        end else if (i_run_tgl) begin
            w_state_nxt = (r_state == c_ST_RUN) ? c_ST_STOP : c_ST_RUN;
        end else if (i_step) begin
            if (r_state == c_ST_STOP) begin
                w_state_nxt     = c_ST_STEP;
                w_step_half_nxt = 1'b0;
            end
        end else if (i_show_tgl) begin
            w_show_nxt = ~r_show;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= c_ST_RUN;
            r_shadow    <= c_RST;
            r_show      <= 1'b0;
            r_step_half <= 1'b0;
            r_pend      <= 1'b0;
            r_running   <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_show      <= w_show_nxt;
            r_step_half <= w_step_half_nxt;
            r_pend      <= (w_shadow_nxt != w_active_nxt);
            r_running   <= (w_state_nxt == c_ST_RUN);
        end
    end

    assign o_clk_div = w_clk_div;
    assign o_clk_out = w_clk_div & r_show;
    assign o_tick    = w_tick;
    assign o_limit   = r_shadow;
    assign o_running = r_running;
    assign o_show    = r_show;
    assign o_pend    = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Directed self-checking bench for clk_div_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, inc, dec, run_tgl, step, show_tgl;
    logic       clk_div, clk_out, tick, running, show, pend;
    logic [7:0] limit;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    clk_div_ctrl dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_inc      (inc),
        .i_dec      (dec),
        .i_run_tgl  (run_tgl),
        .i_step     (step),
        .i_show_tgl (show_tgl),
        .o_clk_div  (clk_div),
        .o_clk_out  (clk_out),
        .o_tick     (tick),
        .o_limit    (limit),
        .o_running  (running),
        .o_show     (show),
        .o_pend     (pend)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic a_inc, input logic a_dec, input logic a_run,
                       input logic a_step, input logic a_show);
        inc = a_inc; dec = a_dec; run_tgl = a_run; step = a_step; show_tgl = a_show;
        cyc();
        inc = 0; dec = 0; run_tgl = 0; step = 0; show_tgl = 0;
    endtask

    // Cycles until the next tick; -1 when the budget expires.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < budget);
        if (!tick) n = -1;
    endtask

    task automatic test_reset();
        reset_n = 0; inc = 0; dec = 0; run_tgl = 0; step = 0; show_tgl = 0;
        repeat (3) cyc();
        tests_run++; if (clk_div !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_div: got %0b expected 0", clk_div); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %0b expected 0", tick); end
        tests_run++; if (limit !== 8'd1) begin tests_failed++; $display("FAIL reset_limit: got %0d expected 1", limit); end
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL reset_running: got %0b expected 1", running); end
        tests_run++; if (show !== 1'b0) begin tests_failed++; $display("FAIL reset_show: got %0b expected 0", show); end
        tests_run++; if (pend !== 1'b0) begin tests_failed++; $display("FAIL reset_pend: got %0b expected 0", pend); end
        tests_run++; if (clk_out !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_out: got %0b expected 0", clk_out); end
    endtask

    task automatic test_free_run();
        logic exp_tick, exp_clk;
        reset_n = 1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            exp_tick = (i % 2 == 0);
            exp_clk  = ((i / 2) % 2 == 1);
            tests_run++; if (tick !== exp_tick) begin tests_failed++; $display("FAIL free_tick[%0d]: got %0b expected %0b", i, tick, exp_tick); end
            tests_run++; if (clk_div !== exp_clk) begin tests_failed++; $display("FAIL free_clk[%0d]: got %0b expected %0b", i, clk_div, exp_clk); end
        end
    endtask

    task automatic test_inc_pend();
        int n;
        inc = 1;
        repeat (3) cyc();
        inc = 0;
        tests_run++; if (limit !== 8'd4) begin tests_failed++; $display("FAIL inc3_limit: got %0d expected 4", limit); end
        tests_run++; if (pend !== 1'b1) begin tests_failed++; $display("FAIL inc3_pend_before_wrap: got %0b expected 1", pend); end
        wait_tick(10, n);
        tests_run++; if (n < 0 || pend !== 1'b0) begin tests_failed++; $display("FAIL inc3_pend_after_wrap: got n=%0d pend=%0b expected tick with pend 0", n, pend); end
        for (int k = 0; k < 2; k++) begin
            wait_tick(20, n);
            tests_run++; if (n !== 5) begin tests_failed++; $display("FAIL inc3_half_period[%0d]: got %0d expected 5", k, n); end
        end
    endtask

    task automatic test_saturation();
        inc = 1;
        repeat (200) cyc();
        inc = 0;
        tests_run++; if (limit !== 8'd200) begin tests_failed++; $display("FAIL sat_reach_max: got %0d expected 200", limit); end
        cmd(1, 0, 0, 0, 0);
        tests_run++; if (limit !== 8'd200) begin tests_failed++; $display("FAIL sat_hold_max: got %0d expected 200", limit); end
        cmd(0, 1, 0, 0, 0);
        tests_run++; if (limit !== 8'd199) begin tests_failed++; $display("FAIL sat_dec_from_max: got %0d expected 199", limit); end
        dec = 1;
        repeat (200) cyc();
        dec = 0;
        tests_run++; if (limit !== 8'd1) begin tests_failed++; $display("FAIL sat_reach_min: got %0d expected 1", limit); end
        cmd(0, 1, 0, 0, 0);
        tests_run++; if (limit !== 8'd1) begin tests_failed++; $display("FAIL sat_hold_min: got %0d expected 1", limit); end
    endtask

    task automatic test_step();
        int n, nticks;
        reset_n = 0;
        repeat (2) cyc();
        reset_n = 1;
        cmd(0, 0, 1, 0, 0);
        tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL step_stop_running: got %0b expected 0", running); end
        cmd(1, 0, 0, 0, 0);
        tests_run++; if (limit !== 8'd2 || pend !== 1'b1) begin tests_failed++; $display("FAIL step_stop_inc: got limit=%0d pend=%0b expected 2/1", limit, pend); end
        cyc();
        tests_run++; if (pend !== 1'b0) begin tests_failed++; $display("FAIL step_stop_load: got pend=%0b expected 0", pend); end
        nticks = 0;
        repeat (4) begin cyc(); if (tick) nticks++; end
        tests_run++; if (nticks !== 0 || clk_div !== 1'b0) begin tests_failed++; $display("FAIL step_stop_hold: got ticks=%0d clk=%0b expected 0/0", nticks, clk_div); end
        cmd(0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            wait_tick(10, n);
            tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL step_tick_gap[%0d]: got %0d expected 3", k, n); end
        end
        nticks = 0;
        repeat (10) begin cyc(); if (tick) nticks++; end
        tests_run++; if (nticks !== 0) begin tests_failed++; $display("FAIL step_extra_ticks: got %0d expected 0", nticks); end
        tests_run++; if (clk_div !== 1'b0 || running !== 1'b0) begin tests_failed++; $display("FAIL step_end_state: got clk=%0b running=%0b expected 0/0", clk_div, running); end
    endtask

    task automatic test_priority();
        int n;
        cmd(1, 0, 0, 0, 1);
        tests_run++; if (limit !== 8'd3 || show !== 1'b0) begin tests_failed++; $display("FAIL prio_inc_show: got limit=%0d show=%0b expected 3/0", limit, show); end
        cmd(1, 1, 0, 0, 0);
        tests_run++; if (limit !== 8'd4) begin tests_failed++; $display("FAIL prio_inc_dec: got %0d expected 4", limit); end
        cmd(0, 1, 1, 0, 0);
        tests_run++; if (limit !== 8'd3 || running !== 1'b0) begin tests_failed++; $display("FAIL prio_dec_run: got limit=%0d running=%0b expected 3/0", limit, running); end
        cmd(0, 0, 0, 0, 1);
        tests_run++; if (show !== 1'b1 || clk_out !== 1'b0) begin tests_failed++; $display("FAIL prio_show: got show=%0b clk_out=%0b expected 1/0", show, clk_out); end
        cmd(0, 0, 1, 1, 0);
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL prio_run_step: got %0b expected 1", running); end
        wait_tick(20, n);
        tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL prio_first_tick: got %0d expected 4", n); end
        tests_run++; if (clk_div !== 1'b1 || clk_out !== 1'b1) begin tests_failed++; $display("FAIL prio_clk_out: got clk=%0b clk_out=%0b expected 1/1", clk_div, clk_out); end
    endtask

    task automatic test_reset_mid_step();
        int n;
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 1, 0);
        cyc();
        reset_n = 0;
        cyc();
        reset_n = 1;
        tests_run++; if (running !== 1'b1 || limit !== 8'd1) begin tests_failed++; $display("FAIL rst_step_state: got running=%0b limit=%0d expected 1/1", running, limit); end
        tests_run++; if (show !== 1'b0 || pend !== 1'b0 || clk_div !== 1'b0) begin tests_failed++; $display("FAIL rst_step_flags: got show=%0b pend=%0b clk=%0b expected 0/0/0", show, pend, clk_div); end
        wait_tick(10, n);
        tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL rst_step_first_tick: got %0d expected 2", n); end
        cmd(0, 0, 0, 1, 0);
        tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL step_in_run_state: got %0b expected 1", running); end
        wait_tick(10, n);
        tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL step_in_run_tick: got %0d expected 1", n); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_inc_pend();
        test_saturation();
        test_step();
        test_priority();
        test_reset_mid_step();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
